// File: rtl/dm_cache_ctrl_if.sv
// rtl/dm_cache_ctrl_if.sv - core data port and memory port bundle of the direct-mapped cache
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_read;
    logic              cpu_write;
    logic              flush;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              hit;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wack;

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, flush,
        output mem_rdata, mem_rvalid, mem_wack,
        input  cpu_rdata, cpu_stall, hit,
        input  mem_req, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, flush,
        input  mem_rdata, mem_rvalid, mem_wack,
        output cpu_rdata, cpu_stall, hit,
        output mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through no-write-allocate cache controller
// Burst refill is critical-word-first; flush during a transaction waits for it to finish.
module dm_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 4,
    parameter int WORDS  = 4
) (
    input logic          clk,
    input logic          rst,
    dm_cache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS];

    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [OFF_W-1:0]  cnt;
    logic              flush_pend;

    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_off;
    logic [TAG_W-1:0]  c_tag;
    logic [IDX_W-1:0]  c_idx;
    logic [OFF_W-1:0]  c_off;
    logic [OFF_W-1:0]  fill_off;
    logic              hit_w;
    logic              last_beat;
    logic              flush_now;

    assign a_tag = bus.cpu_addr[ADDR_W-1:IDX_W+OFF_W];
    assign a_idx = bus.cpu_addr[IDX_W+OFF_W-1:OFF_W];
    assign a_off = bus.cpu_addr[OFF_W-1:0];
    assign c_tag = cap_addr[ADDR_W-1:IDX_W+OFF_W];
    assign c_idx = cap_addr[IDX_W+OFF_W-1:OFF_W];
    assign c_off = cap_addr[OFF_W-1:0];

    // Beats land at the captured offset plus beat count, wrapping within the line.
    assign fill_off  = c_off + cnt;
    assign last_beat = (state == S_REFILL) && bus.mem_rvalid && (cnt == OFF_W'(WORDS - 1));
    assign flush_now = flush_pend || bus.flush;

    assign hit_w   = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign bus.hit = hit_w;

    assign bus.mem_addr  = cap_addr;
    assign bus.mem_wdata = cap_wdata;

    always_comb begin
        bus.cpu_stall = 1'b0;
        case (state)
            S_IDLE:   bus.cpu_stall = bus.cpu_write || (bus.cpu_read && !hit_w);
            S_REFILL: bus.cpu_stall = 1'b1;
            S_WRITE:  bus.cpu_stall = !bus.mem_wack;
            default:  bus.cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            valid         <= '0;
            bus.cpu_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            cnt           <= '0;
            flush_pend    <= 1'b0;
            cap_addr      <= '0;
            cap_wdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cpu_write) begin
                        cap_addr   <= bus.cpu_addr;
                        cap_wdata  <= bus.cpu_wdata;
                        bus.mem_we <= 1'b1;
                        state      <= S_WRITE;
                    end else if (bus.cpu_read) begin
                        if (hit_w) begin
                            bus.cpu_rdata <= data_mem[{a_idx, a_off}];
                        end else begin
                            cap_addr     <= bus.cpu_addr;
                            valid[a_idx] <= 1'b0;
                            cnt          <= '0;
                            bus.mem_req  <= 1'b1;
                            state        <= S_REFILL;
                        end
                    end
                    // Flush last so it wins over any valid update above.
                    if (bus.flush) begin
                        valid <= '0;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last_beat) begin
                        valid[c_idx] <= 1'b1;
                        if (flush_now) begin
                            valid <= '0;
                        end
                        flush_pend  <= 1'b0;
                        bus.mem_req <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.mem_wack) begin
                        if (flush_now) begin
                            valid <= '0;
                        end
                        flush_pend <= 1'b0;
                        bus.mem_we <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.cpu_write && hit_w) begin
            data_mem[{a_idx, a_off}] <= bus.cpu_wdata;
        end
        if (state == S_REFILL && bus.mem_rvalid) begin
            data_mem[{c_idx, fill_off}] <= bus.mem_rdata;
            if (last_beat) begin
                tag_mem[c_idx] <= c_tag;
            end
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard bench for dm_cache_ctrl with a burst memory model
module tb_dm_cache_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(4), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'h0000_9E37);
    endfunction

    // Core-side reference contents and the memory model's own backing store.
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] rd_exp_q [$];
    logic [63:0] wr_exp_q [$];
    logic [63:0] wr_obs_q [$];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : init_word(a);
    endfunction

    int          bursts     = 0;
    int          beat_k     = 0;
    int          wr_cnt     = 0;
    int          wack_delay = 1;
    bit          in_burst   = 0;
    bit          gaps       = 0;
    logic [31:0] burst_addr = '0;
    logic [1:0]  beat_w;

    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_wack   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_rvalid = 1'b0;
            bus.mem_wack   = 1'b0;
            if (!bus.mem_req) begin
                in_burst = 0;
            end else begin
                if (!in_burst) begin
                    in_burst   = 1;
                    beat_k     = 0;
                    bursts++;
                    burst_addr = bus.mem_addr;
                end
                if (beat_k < 4 && !(gaps && $urandom_range(0, 2) == 0)) begin
                    beat_w         = burst_addr[1:0] + 2'(beat_k);
                    bus.mem_rdata  = mem_rd({burst_addr[31:2], beat_w});
                    bus.mem_rvalid = 1'b1;
                    beat_k++;
                end
            end
            if (!bus.mem_we) begin
                wr_cnt = 0;
            end else begin
                wr_cnt++;
                if (wr_cnt > wack_delay) begin
                    bus.mem_wack = 1'b1;
                    mem_store[bus.mem_addr] = bus.mem_wdata;
                    wr_obs_q.push_back({bus.mem_addr, bus.mem_wdata});
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input int exp_miss, input int exp_stall,
                           input bit flush_mid);
        int          b0;
        int          st;
        int          cyc;
        bit          done;
        bit          fl;
        logic [31:0] exp;
        b0 = bursts; st = 0; cyc = 0; done = 0; fl = 0;
        rd_exp_q.push_back(ref_rd(addr));
        @(posedge clk);
        #1;
        bus.cpu_addr = addr;
        bus.cpu_read = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.flush = 1'b0;
            if (bus.cpu_stall) begin
                st++;
                if (flush_mid && !fl && bus.mem_req) begin
                    bus.flush = 1'b1;
                    fl = 1;
                end
            end else begin
                done = 1;
            end
        end
        chk("rd_done", done, 1);
        chk("rd_hit", bus.hit, 1);
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        bus.flush    = 1'b0;
        exp = rd_exp_q.pop_front();
        chk("rd_data", bus.cpu_rdata, exp);
        if (exp_miss >= 0) chk("rd_bursts", bursts - b0, exp_miss);
        if (exp_stall >= 0) chk("rd_stall", st, exp_stall);
        if (exp_miss > 0) chk("burst_addr", burst_addr, addr);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int exp_hit, input int exp_stall);
        int st;
        int cyc;
        bit done;
        st = 0; cyc = 0; done = 0;
        wr_exp_q.push_back({addr, data});
        ref_mem[addr] = data;
        @(posedge clk);
        #1;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_write = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (cyc == 0 && exp_hit >= 0) chk("wr_hit", bus.hit, exp_hit);
            cyc++;
            if (bus.cpu_stall) st++;
            else done = 1;
        end
        chk("wr_done", done, 1);
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        if (exp_stall >= 0) chk("wr_stall", st, exp_stall);
        if (wr_obs_q.size() == 0) begin
            chk("wr_seen", 0, 1);
            void'(wr_exp_q.pop_front());
        end else begin
            chk("wr_addr_data", wr_obs_q.pop_front(), wr_exp_q.pop_front());
        end
    endtask

    initial begin
        int cyc;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.flush     = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_hit", bus.hit, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Refill then hits across the line
        do_read(32'h10, 1, -1, 0);
        do_read(32'h12, 0, 0, 0);
        do_read(32'h11, 0, 0, 0);
        do_read(32'h13, 0, 0, 0);

        // Critical word first with offset wrap
        do_read(32'h23, 1, -1, 0);
        for (int k = 0; k < 3; k++) do_read(32'h20 + 32'(k), 0, 0, 0);

        // Write hit with slow acknowledge, then read back without refill
        do_read(32'h12, 1, -1, 0);
        wack_delay = 3;
        do_write(32'h12, 32'hDEAD, 1, 4);
        do_read(32'h12, 0, 0, 0);

        // Write miss does not allocate; minimum store latency
        wack_delay = 0;
        do_write(32'h50, 32'h5A5A, 0, 1);
        do_read(32'h50, 1, -1, 0);

        // Reset two beats into a refill
        gaps = 1;
        @(posedge clk);
        #1;
        bus.cpu_addr = 32'h34;
        bus.cpu_read = 1'b1;
        cyc = 0;
        while (beat_k != 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached", beat_k, 2);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.cpu_read = 1'b0;
        #1;
        chk("rst_mid_req", bus.mem_req, 0);
        chk("rst_mid_stall", bus.cpu_stall, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_mid_hit", bus.hit, 0);
        do_read(32'h34, 1, -1, 0);
        do_read(32'h37, 0, 0, 0);

        // Flush in idle, then flush during a refill
        gaps = 0;
        do_read(32'h14, 1, -1, 0);
        do_read(32'h28, 1, -1, 0);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.cpu_addr = 32'h14;
        #1 chk("flush_hit_a", bus.hit, 0);
        bus.cpu_addr = 32'h28;
        #1 chk("flush_hit_b", bus.hit, 0);
        do_read(32'h14, 1, -1, 0);
        do_read(32'h3C, 2, -1, 1);
        do_read(32'h3D, 0, 0, 0);
        do_read(32'h14, 1, -1, 0);

        // Mixed random traffic
        gaps = 1;
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 127));
            wack_delay = int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) do_write(a, $urandom, -1, -1);
            do_read(a, -1, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
